// File: rtl/mpc_pkg.sv
// mpc_pkg: shared configuration codes, register indices and pad bank widths for mpc
package mpc_pkg;
    localparam logic [1:0] CFG_SAFE  = 2'd0;
    localparam logic [1:0] CFG_GPIO  = 2'd1;
    localparam logic [1:0] CFG_COUNT = 2'd2;
    localparam logic [1:0] CFG_ADD   = 2'd3;
    localparam logic [3:0] REG_EAST_OUT  = 4'd0;
    localparam logic [3:0] REG_WEST_OUT  = 4'd1;
    localparam logic [3:0] REG_NORTH_OUT = 4'd2;
    localparam logic [3:0] REG_EAST_OE   = 4'd3;
    localparam logic [3:0] REG_WEST_OE   = 4'd4;
    localparam logic [3:0] REG_NORTH_OE  = 4'd5;
    localparam logic [3:0] REG_PADIN_EW  = 4'd6;
    localparam logic [3:0] REG_PADIN_N   = 4'd7;
    localparam logic [3:0] REG_CFG_OVR   = 4'd8;
    localparam int EAST_W  = 14;
    localparam int WEST_W  = 14;
    localparam int NORTH_W = 10;
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction
endpackage

// File: rtl/mpc_wb_regs.sv
// mpc_wb_regs: Wishbone classic slave and pad register file; CFG_OVR exists only with MPC_CFG_OVR_EN
module mpc_wb_regs
    import mpc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stb,
    input  logic               i_cyc,
    input  logic               i_we,
    input  logic [3:0]         i_sel,
    input  logic [31:0]        i_dat,
    input  logic [31:0]        i_adr,
    input  logic [EAST_W-1:0]  i_east,
    input  logic [WEST_W-1:0]  i_west,
    input  logic [NORTH_W-1:0] i_north,
    input  logic [EAST_W-1:0]  i_cnt,
    input  logic [1:0]         i_cfg,
    output logic               o_ack,
    output logic [31:0]        o_dat,
    output logic [EAST_W-1:0]  o_east_out,
    output logic [WEST_W-1:0]  o_west_out,
    output logic [NORTH_W-1:0] o_north_out,
    output logic [EAST_W-1:0]  o_east_oe,
    output logic [WEST_W-1:0]  o_west_oe,
    output logic [NORTH_W-1:0] o_north_oe,
    output logic [1:0]         o_cfg
);
    logic               r_ack;
    logic [31:0]        r_dat;
    logic [EAST_W-1:0]  r_east_out, r_east_oe;
    logic [WEST_W-1:0]  r_west_out, r_west_oe;
    logic [NORTH_W-1:0] r_north_out, r_north_oe;
    logic               w_req, w_hit, w_unused;
    logic [3:0]         w_idx;
    logic [31:0]        w_rd, w_wd;
`ifdef MPC_CFG_OVR_EN
    logic [2:0]         r_ovr;
`endif
    assign w_req = i_stb & i_cyc & ~r_ack;
    assign w_hit = i_adr[31:6] == BASE_ADDR[31:6];
    assign w_idx = i_adr[5:2];
    always_comb begin
        w_rd = '0;
        if (w_hit)
            case (w_idx)
                REG_EAST_OUT:  w_rd = 32'(r_east_out);
                REG_WEST_OUT:  w_rd = 32'(r_west_out);
                REG_NORTH_OUT: w_rd = 32'(r_north_out);
                REG_EAST_OE:   w_rd = 32'(r_east_oe);
                REG_WEST_OE:   w_rd = 32'(r_west_oe);
                REG_NORTH_OE:  w_rd = 32'(r_north_oe);
                REG_PADIN_EW:  w_rd = {2'b0, i_west, 2'b0, i_east};
                REG_PADIN_N:   w_rd = {2'b0, i_cnt, 6'b0, i_north};
`ifdef MPC_CFG_OVR_EN
                REG_CFG_OVR:   w_rd = 32'(r_ovr);
`endif
                default:       w_rd = '0;
            endcase
    end
    // Byte-lane merge over the current register value, so unselected lanes keep their contents
    assign w_wd = byte_merge(w_rd, i_dat, i_sel);
    assign w_unused = &{1'b0, i_adr[1:0], w_wd[31:EAST_W]};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_east_out  <= '0;
            r_west_out  <= '0;
            r_north_out <= '0;
            r_east_oe   <= '0;
            r_west_oe   <= '0;
            r_north_oe  <= '0;
`ifdef MPC_CFG_OVR_EN
            r_ovr       <= '0;
`endif
        end else begin
            r_ack <= w_req;
            if (w_req && !i_we) r_dat <= w_rd;
            if (w_req && i_we && w_hit)
                case (w_idx)
                    REG_EAST_OUT:  r_east_out  <= w_wd[EAST_W-1:0];
                    REG_WEST_OUT:  r_west_out  <= w_wd[WEST_W-1:0];
                    REG_NORTH_OUT: r_north_out <= w_wd[NORTH_W-1:0];
                    REG_EAST_OE:   r_east_oe   <= w_wd[EAST_W-1:0];
                    REG_WEST_OE:   r_west_oe   <= w_wd[WEST_W-1:0];
                    REG_NORTH_OE:  r_north_oe  <= w_wd[NORTH_W-1:0];
`ifdef MPC_CFG_OVR_EN
                    REG_CFG_OVR:   r_ovr       <= w_wd[2:0];
`endif
                    default: ;
                endcase
        end
    end
`ifdef MPC_CFG_OVR_EN
    assign o_cfg = r_ovr[2] ? r_ovr[1:0] : i_cfg;
`else
    assign o_cfg = i_cfg;
`endif
    assign o_ack       = r_ack;
    assign o_dat       = r_dat;
    assign o_east_out  = r_east_out;
    assign o_west_out  = r_west_out;
    assign o_north_out = r_north_out;
    assign o_east_oe   = r_east_oe;
    assign o_west_oe   = r_west_oe;
    assign o_north_oe  = r_north_oe;
endmodule

// File: rtl/mpc.sv
// mpc: multi-project pad controller (safe/GPIO/counter/adder pad mux); MPC_CFG_OVR_EN enables the CFG_OVR register
module mpc
    import mpc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [1:0]         configuration,
    input  logic [EAST_W-1:0]  IO_east_i,
    output logic [EAST_W-1:0]  IO_east_o,
    output logic [EAST_W-1:0]  IO_east_oe,
    input  logic [WEST_W-1:0]  IO_west_i,
    output logic [WEST_W-1:0]  IO_west_o,
    output logic [WEST_W-1:0]  IO_west_oe,
    input  logic [NORTH_W-1:0] IO_north_i,
    output logic [NORTH_W-1:0] IO_north_o,
    output logic [NORTH_W-1:0] IO_north_oe,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o
);
    logic [EAST_W-1:0]  r_cnt, r_east_o, r_east_oe, w_east_out, w_east_oe, w_east_o_n, w_east_oe_n;
    logic [WEST_W-1:0]  r_west_o, r_west_oe, w_west_out, w_west_oe, w_west_o_n, w_west_oe_n;
    logic [NORTH_W-1:0] r_north_o, r_north_oe, w_north_out, w_north_oe, w_north_o_n, w_north_oe_n, w_sum;
    logic [1:0]         w_cfg;
    mpc_wb_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .i_stb(wbs_stb_i), .i_cyc(wbs_cyc_i), .i_we(wbs_we_i), .i_sel(wbs_sel_i),
        .i_dat(wbs_dat_i), .i_adr(wbs_adr_i),
        .i_east(IO_east_i), .i_west(IO_west_i), .i_north(IO_north_i),
        .i_cnt(r_cnt), .i_cfg(configuration),
        .o_ack(wbs_ack_o), .o_dat(wbs_dat_o),
        .o_east_out(w_east_out), .o_west_out(w_west_out), .o_north_out(w_north_out),
        .o_east_oe(w_east_oe), .o_west_oe(w_west_oe), .o_north_oe(w_north_oe),
        .o_cfg(w_cfg)
    );
    assign w_sum = IO_east_i[NORTH_W-1:0] + IO_west_i[NORTH_W-1:0];
    always_comb begin
        w_east_o_n   = w_cfg == CFG_GPIO ? w_east_out : w_cfg == CFG_COUNT ? r_cnt : '0;
        w_east_oe_n  = w_cfg == CFG_GPIO ? w_east_oe : w_cfg == CFG_COUNT ? '1 : '0;
        w_west_o_n   = w_cfg == CFG_GPIO ? w_west_out : w_cfg == CFG_COUNT ? ~r_cnt : '0;
        w_west_oe_n  = w_cfg == CFG_GPIO ? w_west_oe : w_cfg == CFG_COUNT ? '1 : '0;
        w_north_o_n  = w_cfg == CFG_GPIO ? w_north_out : w_cfg == CFG_COUNT ? r_cnt[EAST_W-1:EAST_W-NORTH_W] :
                       w_cfg == CFG_ADD ? w_sum : '0;
        w_north_oe_n = w_cfg == CFG_GPIO ? w_north_oe : (w_cfg == CFG_COUNT || w_cfg == CFG_ADD) ? '1 : '0;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt      <= '0;
            r_east_o   <= '0;
            r_east_oe  <= '0;
            r_west_o   <= '0;
            r_west_oe  <= '0;
            r_north_o  <= '0;
            r_north_oe <= '0;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_east_o   <= w_east_o_n;
            r_east_oe  <= w_east_oe_n;
            r_west_o   <= w_west_o_n;
            r_west_oe  <= w_west_oe_n;
            r_north_o  <= w_north_o_n;
            r_north_oe <= w_north_oe_n;
        end
    end
    assign IO_east_o   = r_east_o;
    assign IO_east_oe  = r_east_oe;
    assign IO_west_o   = r_west_o;
    assign IO_west_oe  = r_west_oe;
    assign IO_north_o  = r_north_o;
    assign IO_north_oe = r_north_oe;
endmodule

// File: tb/tb_mpc.sv
// tb_mpc: directed self-checking bench for mpc
module tb_mpc;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
    logic [1:0]  configuration = 2'd0;
    logic [13:0] IO_east_i = '0, IO_west_i = '0;
    logic [9:0]  IO_north_i = '0;
    logic [13:0] IO_east_o, IO_east_oe, IO_west_o, IO_west_oe;
    logic [9:0]  IO_north_o, IO_north_oe;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0, wbs_ack_o;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0, wbs_dat_o;
    logic [13:0] m_cnt = '0;
    int n_pass = 0, n_total = 0;

    mpc dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .configuration(configuration),
        .IO_east_i(IO_east_i), .IO_east_o(IO_east_o), .IO_east_oe(IO_east_oe),
        .IO_west_i(IO_west_i), .IO_west_o(IO_west_o), .IO_west_oe(IO_west_oe),
        .IO_north_i(IO_north_i), .IO_north_o(IO_north_o), .IO_north_oe(IO_north_oe),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) m_cnt <= wb_rst_i ? 14'd0 : m_cnt + 14'd1;

    task automatic step(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit got = 0;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            got = wbs_ack_o;
        end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        if (!got) begin
            n_total++;
            $display("FAIL wb_write_ack: no ack for adr %h", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        bit got = 0;
        wbs_adr_i = adr; wbs_sel_i = 4'hF;
        wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            got = wbs_ack_o;
        end
        wbs_stb_i = 0; wbs_cyc_i = 0;
        dat = got ? wbs_dat_o : 'x;
        if (!got) begin
            n_total++;
            $display("FAIL wb_read_ack: no ack for adr %h", adr);
        end
    endtask

    task automatic test_reset;
        wb_rst_i = 1; configuration = 2; step(2);
        n_total++; if ({IO_east_o, IO_east_oe, IO_west_o, IO_west_oe, IO_north_o, IO_north_oe} !== '0)
            $display("FAIL reset_pads: got %h/%h/%h want 0", IO_east_oe, IO_west_oe, IO_north_oe); else n_pass++;
        n_total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0)
            $display("FAIL reset_wb: ack %b dat %h want 0/0", wbs_ack_o, wbs_dat_o); else n_pass++;
        wb_rst_i = 0; configuration = 0; step(1);
        n_total++; if ({IO_east_o, IO_east_oe, IO_west_o, IO_west_oe, IO_north_o, IO_north_oe} !== '0)
            $display("FAIL cfg0_pads: got oe %h/%h/%h want 0", IO_east_oe, IO_west_oe, IO_north_oe); else n_pass++;
        configuration = 1; step(1);
        n_total++; if ({IO_east_o, IO_east_oe, IO_west_o, IO_west_oe, IO_north_o, IO_north_oe} !== '0)
            $display("FAIL cfg1_pads: got oe %h/%h/%h want 0", IO_east_oe, IO_west_oe, IO_north_oe); else n_pass++;
        configuration = 2; step(1);
        n_total++; if (IO_east_oe !== 14'h3FFF || IO_west_oe !== 14'h3FFF || IO_north_oe !== 10'h3FF)
            $display("FAIL cfg2_oe: got %h/%h/%h want 3fff/3fff/3ff", IO_east_oe, IO_west_oe, IO_north_oe); else n_pass++;
        configuration = 3; step(1);
        n_total++; if (IO_north_oe !== 10'h3FF || IO_east_oe !== 14'h0 || IO_west_oe !== 14'h0)
            $display("FAIL cfg3_oe: got %h/%h/%h want 0/0/3ff", IO_east_oe, IO_west_oe, IO_north_oe); else n_pass++;
    endtask

    task automatic test_add;
        configuration = 3; IO_east_i = 30; IO_west_i = 35; step(1);
        n_total++; if (IO_north_o !== 10'd65) $display("FAIL add_65: got %0d want 65", IO_north_o); else n_pass++;
        IO_east_i = 1023; IO_west_i = 2; step(1);
        n_total++; if (IO_north_o !== 10'd1) $display("FAIL add_wrap: got %0d want 1", IO_north_o); else n_pass++;
        IO_east_i = 14'h3C05; IO_west_i = 14'h2C03; step(1);
        n_total++; if (IO_north_o !== 10'd8 || IO_east_o !== 14'h0 || IO_west_o !== 14'h0)
            $display("FAIL add_low_bits: got n %0d e %h w %h want 8/0/0", IO_north_o, IO_east_o, IO_west_o); else n_pass++;
    endtask

    task automatic test_count;
        wb_rst_i = 1; configuration = 2; step(1);
        wb_rst_i = 0; step(20);
        n_total++; if (IO_east_o !== 14'd19 || IO_west_o !== 14'h3FEC || IO_north_o !== 10'd1)
            $display("FAIL count_20: got %h/%h/%h want 0013/3fec/001", IO_east_o, IO_west_o, IO_north_o); else n_pass++;
        step(16364);
        n_total++; if (IO_east_o !== 14'h3FFF || IO_west_o !== 14'h0 || IO_north_o !== 10'h3FF)
            $display("FAIL count_max: got %h/%h/%h want 3fff/0000/3ff", IO_east_o, IO_west_o, IO_north_o); else n_pass++;
        step(1);
        n_total++; if (IO_east_o !== 14'h0 || IO_west_o !== 14'h3FFF)
            $display("FAIL count_wrap: got %h/%h want 0000/3fff", IO_east_o, IO_west_o); else n_pass++;
        step(16384);
        n_total++; if (IO_east_o !== 14'h0) $display("FAIL count_full_lap: got %h want 0000", IO_east_o); else n_pass++;
    endtask

    task automatic test_gpio;
        logic [31:0] d;
        configuration = 0;
        wb_write(BASE + 32'h00, 32'h1555, 4'hF);
        wb_write(BASE + 32'h0C, 32'h3FFF, 4'hF);
        configuration = 1; step(1);
        n_total++; if (IO_east_o !== 14'h1555 || IO_east_oe !== 14'h3FFF || IO_west_oe !== 14'h0)
            $display("FAIL gpio_east: got %h/%h want 1555/3fff", IO_east_o, IO_east_oe); else n_pass++;
        wb_write(BASE + 32'h00, 32'hFF00, 4'b0001);
        n_total++; if (IO_east_o !== 14'h1555) $display("FAIL gpio_latency: got %h want 1555", IO_east_o); else n_pass++;
        step(1);
        n_total++; if (IO_east_o !== 14'h1500) $display("FAIL gpio_sel0: got %h want 1500", IO_east_o); else n_pass++;
        wb_write(BASE + 32'h00, 32'h0000_2A00, 4'b0010);
        wb_read(BASE + 32'h00, d);
        n_total++; if (d !== 32'h2A00) $display("FAIL gpio_sel1: got %h want 00002a00", d); else n_pass++;
        wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0100);
        wb_read(BASE + 32'h04, d);
        n_total++; if (d !== 32'h0) $display("FAIL gpio_sel2_ignored: got %h want 0", d); else n_pass++;
        wb_write(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
        wb_write(BASE + 32'h14, 32'h0000_02AA, 4'hF);
        wb_read(BASE + 32'h08, d);
        n_total++; if (d !== 32'h3FF) $display("FAIL north_out_rd: got %h want 000003ff", d); else n_pass++;
        step(1);
        n_total++; if (IO_north_o !== 10'h3FF || IO_north_oe !== 10'h2AA)
            $display("FAIL gpio_north: got %h/%h want 3ff/2aa", IO_north_o, IO_north_oe); else n_pass++;
    endtask

    task automatic test_read;
        logic [31:0] d;
        IO_east_i = 30; IO_west_i = 35; IO_north_i = 10'h155;
        wb_read(BASE + 32'h18, d);
        n_total++; if (d !== 32'h0023_001E) $display("FAIL padin_ew: got %h want 0023001e", d); else n_pass++;
        step(1);
        n_total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0023_001E)
            $display("FAIL ack_single: ack %b dat %h want 0/0023001e", wbs_ack_o, wbs_dat_o); else n_pass++;
        wb_read(BASE + 32'h1C, d);
        n_total++; if (d !== {2'b0, m_cnt - 14'd1, 6'b0, 10'h155})
            $display("FAIL padin_n: got %h want %h", d, {2'b0, m_cnt - 14'd1, 6'b0, 10'h155}); else n_pass++;
        wb_read(BASE + 32'h24, d);
        n_total++; if (d !== 32'h0) $display("FAIL reg9: got %h want 0", d); else n_pass++;
        wb_read(BASE + 32'h18, d);
        wb_write(32'h4000_0000, 32'h3FFF, 4'hF);
        n_total++; if (wbs_dat_o !== 32'h0023_001E) $display("FAIL dat_hold: got %h want 0023001e", wbs_dat_o); else n_pass++;
        wb_read(32'h4000_0000, d);
        n_total++; if (d !== 32'h0) $display("FAIL out_of_range_rd: got %h want 0", d); else n_pass++;
        wb_read(BASE + 32'h00, d);
        n_total++; if (d !== 32'h2A00) $display("FAIL out_of_range_wr: got %h want 00002a00", d); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] acks;
        step(1);
        wbs_adr_i = BASE + 32'h18; wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1;
        for (int i = 3; i >= 0; i--) begin
            step(1);
            acks[i] = wbs_ack_o;
        end
        wbs_stb_i = 0; wbs_cyc_i = 0;
        n_total++; if (acks !== 4'b1010) $display("FAIL b2b_ack: got %b want 1010", acks); else n_pass++;
        n_total++; if (wbs_dat_o !== 32'h0023_001E) $display("FAIL b2b_dat: got %h want 0023001e", wbs_dat_o); else n_pass++;
    endtask

    task automatic test_ovr;
        logic [31:0] d;
        configuration = 0; IO_east_i = 30; IO_west_i = 35;
        wb_write(BASE + 32'h20, 32'h7, 4'hF);
        step(1);
`ifdef MPC_CFG_OVR_EN
        n_total++; if (IO_north_o !== 10'd65 || IO_north_oe !== 10'h3FF)
            $display("FAIL ovr_add: got %h/%h want 041/3ff", IO_north_o, IO_north_oe); else n_pass++;
        wb_read(BASE + 32'h20, d);
        n_total++; if (d !== 32'h7) $display("FAIL ovr_rd: got %h want 7", d); else n_pass++;
        wb_write(BASE + 32'h20, 32'h3, 4'hF);
        step(1);
        n_total++; if (IO_north_o !== 10'h0 || IO_north_oe !== 10'h0)
            $display("FAIL ovr_off: got %h/%h want 0/0", IO_north_o, IO_north_oe); else n_pass++;
`else
        n_total++; if (IO_north_o !== 10'h0 || IO_north_oe !== 10'h0)
            $display("FAIL ovr_absent_pads: got %h/%h want 0/0", IO_north_o, IO_north_oe); else n_pass++;
        wb_read(BASE + 32'h20, d);
        n_total++; if (d !== 32'h0) $display("FAIL ovr_absent_rd: got %h want 0", d); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        step(1);
        wbs_adr_i = BASE + 32'h00; wbs_dat_i = 32'h1111; wbs_sel_i = 4'hF;
        wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1; wb_rst_i = 1;
        step(1);
        n_total++; if (wbs_ack_o !== 1'b0) $display("FAIL rst_mid_ack: got %b want 0", wbs_ack_o); else n_pass++;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wb_rst_i = 0;
        step(1);
        wb_read(BASE + 32'h00, d);
        n_total++; if (d !== 32'h0) $display("FAIL rst_mid_drop: got %h want 0", d); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_count;
        test_gpio;
        test_read;
        test_back_to_back;
        test_ovr;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
